// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use stall detection, EX operand forwarding and WB write tracking
module hazard_fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_wreg,
    input  logic             id_regwrite,
    input  logic             id_memread,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [4:0]       wb_wreg,
    output logic             wb_we,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       uses_rs;
        logic       uses_rt;
        logic [4:0] wreg;
        logic       regwrite;
        logic       memread;
    } rec_t;

    rec_t ex, mem, wb, id_rec;

    // A stage produces a usable value for register r; $0 never counts
    function automatic logic hit(input rec_t s, input logic [4:0] r);
        return s.valid & s.regwrite & (s.wreg != 5'd0) & (s.wreg == r);
    endfunction

    // Hazard detection, forwarding select and WB write port, all from current state
    always_comb begin
        id_rec = '{valid: id_valid, rs: id_rs, rt: id_rt, uses_rs: id_uses_rs,
                   uses_rt: id_uses_rt, wreg: id_wreg, regwrite: id_regwrite,
                   memread: id_memread};
        stall  = id_valid & ex.memread &
                 ((id_uses_rs & hit(ex, id_rs)) | (id_uses_rt & hit(ex, id_rt)));
        fwd_a  = (ex.valid & ex.uses_rs & hit(mem, ex.rs)) ? 2'b10 :
                 (ex.valid & ex.uses_rs & hit(wb, ex.rs))  ? 2'b01 : 2'b00;
        fwd_b  = (ex.valid & ex.uses_rt & hit(mem, ex.rt)) ? 2'b10 :
                 (ex.valid & ex.uses_rt & hit(wb, ex.rt))  ? 2'b01 : 2'b00;
        wb_we   = wb.valid & wb.regwrite & (wb.wreg != 5'd0);
        wb_wreg = wb.wreg;
    end

    // Pipeline advance with bubble insertion on stall, plus saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex        <= '0;
            mem       <= '0;
            wb        <= '0;
            stall_cnt <= '0;
        end else begin
            wb  <= mem;
            mem <= ex;
            ex  <= stall ? '0 : id_rec;
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed checks of stall, forwarding, WB port and stall counter
module tb_hazard_fwd_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread;
    logic [4:0]  id_rs, id_rt, id_wreg;
    logic        stall, wb_we, s_stall, s_wb_we;
    logic [1:0]  fwd_a, fwd_b, s_fwd_a, s_fwd_b;
    logic [4:0]  wb_wreg, s_wb_wreg;
    logic [15:0] stall_cnt;
    logic [1:0]  s_stall_cnt;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .stall(stall),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_wreg(wb_wreg), .wb_we(wb_we),
        .stall_cnt(stall_cnt)
    );

    hazard_fwd_unit #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wreg(id_wreg),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .stall(s_stall),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .wb_wreg(s_wb_wreg), .wb_we(s_wb_we),
        .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] wr,
                          input logic rw, input logic mr);
        id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
        id_wreg = wr; id_regwrite = rw; id_memread = mr;
        #1;
    endtask

    task automatic nop();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(1, 5'($urandom), 5'($urandom), 1, 1, 5'($urandom), 1, 1);
        tick();
        set_id(1, 5'($urandom), 5'($urandom), 1, 1, 5'($urandom), 1, 1);
        tick();
        chk("rst_stall", stall, 0);
        chk("rst_fwd_a", fwd_a, 0);
        chk("rst_fwd_b", fwd_b, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb_wreg", wb_wreg, 0);
        chk("rst_cnt", stall_cnt, 0);
        rst_n = 1'b1;
        nop();
        tick();

        // EX-EX forward, then WB forward to rt
        set_id(1, 1, 2, 1, 1, 3, 1, 0); tick();
        set_id(1, 3, 9, 1, 0, 7, 1, 0);
        chk("exex_nostall", stall, 0);
        tick();
        chk("exex_fwd_a", fwd_a, 2'b10);
        chk("exex_fwd_b", fwd_b, 2'b00);
        set_id(1, 12, 3, 0, 1, 8, 1, 0); tick();
        chk("wb_fwd_b", fwd_b, 2'b01);
        chk("wb_fwd_a_unused", fwd_a, 2'b00);
        chk("wb_we_add", wb_we, 1);
        chk("wb_wreg_add", wb_wreg, 3);
        drain();

        // Load-use: exactly one stall, bubble, then WB forward
        set_id(1, 1, 2, 1, 0, 5, 1, 1); tick();
        set_id(1, 5, 6, 1, 1, 6, 1, 0);
        chk("lu_stall", stall, 1);
        tick();
        chk("lu_stall_once", stall, 0);
        chk("lu_bubble_fwd", fwd_a, 2'b00);
        chk("lu_cnt", stall_cnt, 1);
        tick();
        chk("lu_fwd_a", fwd_a, 2'b01);
        chk("lu_wb_wreg", wb_wreg, 5);
        chk("lu_wb_we", wb_we, 1);
        drain();

        // Register matches but operand not used: no stall
        set_id(1, 0, 0, 0, 0, 13, 1, 1); tick();
        set_id(1, 13, 13, 0, 0, 14, 1, 0);
        chk("unused_nostall", stall, 0);
        drain();

        // Double hazard: MEM wins over WB
        set_id(1, 0, 0, 0, 0, 4, 1, 0); tick();
        set_id(1, 0, 0, 0, 0, 4, 1, 0); tick();
        set_id(1, 4, 4, 1, 1, 10, 1, 0); tick();
        chk("dbl_fwd_a", fwd_a, 2'b10);
        chk("dbl_fwd_b", fwd_b, 2'b10);
        drain();

        // $0 destination never stalls, forwards or writes
        set_id(1, 0, 0, 0, 0, 0, 1, 1); tick();
        set_id(1, 0, 0, 1, 1, 11, 1, 0);
        chk("z_stall", stall, 0);
        tick();
        chk("z_fwd_a", fwd_a, 2'b00);
        nop(); tick();
        chk("z_wb_we", wb_we, 0);
        chk("z_cnt", stall_cnt, 1);
        drain();

        // Five load-use pairs: CNT_W=2 instance saturates at 3
        for (int i = 0; i < 5; i++) begin
            set_id(1, 0, 0, 0, 0, 9, 1, 1); tick();
            set_id(1, 0, 9, 0, 1, 10, 1, 0);
            chk("sat_stall", s_stall, 1);
            tick();
            tick();
            chk("sat_cnt", s_stall_cnt, (i + 2 > 3) ? 3 : i + 2);
        end
        drain();
        chk("sat_held", s_stall_cnt, 3);
        chk("wide_cnt", stall_cnt, 6);

        // Reset mid-stall drops in-flight records and clears counters
        set_id(1, 0, 0, 0, 0, 17, 1, 1); tick();
        set_id(1, 17, 0, 1, 0, 18, 1, 0);
        chk("ms_stall", stall, 1);
        rst_n = 1'b0;
        tick();
        chk("ms_stall_clr", stall, 0);
        chk("ms_cnt", stall_cnt, 0);
        chk("ms_sat_cnt", s_stall_cnt, 0);
        rst_n = 1'b1;
        tick();
        chk("ms_after", stall, 0);
        chk("ms_fwd_a", fwd_a, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
